// File: rtl/store_write_arbiter.sv
// Write-path arbiter between the CPU store stage and the boot/debug loader.
// Optional loader anti-starvation counter is built when STORE_ARB_FAIRNESS_EN is defined.
module store_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data,
  input  logic [2:0]  cpu_size,
  input  logic        ldr_valid,
  output logic        ldr_ready,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_data,
  input  logic [2:0]  ldr_size,
  input  logic        ldr_last,
  input  logic        wr_stall,
  output logic        wr_store,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [2:0]  wr_size,
  output logic        wr_src,
  output logic        err_size
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] LDR_BURST = 1'b1;
  localparam logic [2:0] SIZE_MAX  = 3'b010;

  logic [0:0]  state;
  logic [0:0]  state_nxt;
  logic        force_ldr;
  logic        cpu_acc;
  logic        ldr_acc;
  logic [31:0] sel_addr;
  logic [31:0] sel_data;
  logic [2:0]  sel_size;

`ifdef STORE_ARB_FAIRNESS_EN
  logic [3:0] starve_cnt;

  assign force_ldr = (starve_cnt == 4'(STARVE_LIMIT));

  // Counts CPU wins only while the loader is actually waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (ldr_acc || !ldr_valid) begin
      starve_cnt <= '0;
    end else if (cpu_acc) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  logic unused_starve_limit;

  assign force_ldr           = 1'b0;
  assign unused_starve_limit = ^4'(STARVE_LIMIT);
`endif

  always_comb begin
    cpu_ready = 1'b0;
    ldr_ready = 1'b0;
    if (rst_n && !wr_stall) begin
      case (state)
        IDLE: begin
          if (force_ldr) begin
            ldr_ready = ldr_valid;
          end else begin
            cpu_ready = cpu_valid;
            ldr_ready = ldr_valid && !cpu_valid;
          end
        end
        LDR_BURST: ldr_ready = ldr_valid;
        default: ;
      endcase
    end
  end

  assign cpu_acc = cpu_valid && cpu_ready;
  assign ldr_acc = ldr_valid && ldr_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (ldr_acc && !ldr_last) state_nxt = LDR_BURST;
      LDR_BURST: if (ldr_acc && ldr_last)  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    sel_addr = cpu_addr;
    sel_data = cpu_data;
    sel_size = cpu_size;
    if (ldr_acc) begin
      sel_addr = ldr_addr;
      sel_data = ldr_data;
      sel_size = ldr_size;
    end
  end

  // A stalled cycle freezes every wr_* output so a pending strobe is seen exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_store <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_size  <= '0;
      wr_src   <= 1'b0;
      err_size <= 1'b0;
    end else if (!wr_stall) begin
      if (cpu_acc || ldr_acc) begin
        wr_addr  <= sel_addr;
        wr_data  <= sel_data;
        wr_size  <= sel_size;
        wr_src   <= ldr_acc;
        wr_store <= (sel_size <= SIZE_MAX);
        err_size <= (sel_size > SIZE_MAX);
      end else begin
        wr_store <= 1'b0;
        err_size <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_store_write_arbiter.sv
// Directed self-checking bench for store_write_arbiter.
module tb_store_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data;
  logic [2:0]  cpu_size;
  logic        ldr_valid;
  logic        ldr_ready;
  logic [31:0] ldr_addr;
  logic [31:0] ldr_data;
  logic [2:0]  ldr_size;
  logic        ldr_last;
  logic        wr_stall;
  logic        wr_store;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  wr_size;
  logic        wr_src;
  logic        err_size;

  int checks   = 0;
  int failures = 0;

  store_write_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_size(cpu_size),
    .ldr_valid(ldr_valid), .ldr_ready(ldr_ready), .ldr_addr(ldr_addr),
    .ldr_data(ldr_data), .ldr_size(ldr_size), .ldr_last(ldr_last),
    .wr_stall(wr_stall), .wr_store(wr_store), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_size(wr_size), .wr_src(wr_src), .err_size(err_size)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_cpu;

    rst_n = 1'b0; wr_stall = 1'b0;
    cpu_valid = 1'b1; cpu_addr = '0; cpu_data = '0; cpu_size = 3'b010;
    ldr_valid = 1'b1; ldr_addr = '0; ldr_data = '0; ldr_size = 3'b010; ldr_last = 1'b1;
    #12;
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_ldr_ready", ldr_ready, 0);
    chk("rst_wr_store", wr_store, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_err_size", err_size, 0);
    cpu_valid = 1'b0; ldr_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // CPU only
    cpu_valid = 1'b1; cpu_addr = 32'h1000_0004; cpu_data = 32'hDEAD_BEEF; cpu_size = 3'b010;
    #1;
    chk("cpu_only_ready", cpu_ready, 1);
    chk("cpu_only_ldr_ready", ldr_ready, 0);
    tick();
    chk("cpu_only_store", wr_store, 1);
    chk("cpu_only_addr", wr_addr, 32'h1000_0004);
    chk("cpu_only_data", wr_data, 32'hDEAD_BEEF);
    chk("cpu_only_size", wr_size, 3'b010);
    chk("cpu_only_src", wr_src, 0);
    cpu_addr = 32'h1000_0008; cpu_data = 32'h1234_5678; cpu_size = 3'b000;
    #1;
    chk("cpu_b2_ready", cpu_ready, 1);
    tick();
    chk("cpu_b2_data", wr_data, 32'h1234_5678);
    chk("cpu_b2_size", wr_size, 3'b000);
    cpu_valid = 1'b0;
    tick();
    chk("idle_store", wr_store, 0);
    chk("idle_addr_hold", wr_addr, 32'h1000_0008);

    // Loader burst with CPU waiting from beat 2 onward and a gap
    ldr_valid = 1'b1; ldr_addr = 32'h2000_0000; ldr_data = 32'h1111_1111; ldr_size = 3'b010; ldr_last = 1'b0;
    #1;
    chk("ldr_b1_ready", ldr_ready, 1);
    tick();
    chk("ldr_b1_addr", wr_addr, 32'h2000_0000);
    chk("ldr_b1_src", wr_src, 1);
    chk("ldr_b1_store", wr_store, 1);
    ldr_addr = 32'h2000_0004; ldr_data = 32'h2222_2222;
    cpu_valid = 1'b1; cpu_addr = 32'h3000_0000; cpu_data = 32'hA5A5_A5A5; cpu_size = 3'b010;
    #1;
    chk("ldr_b2_ready", ldr_ready, 1);
    chk("ldr_b2_cpu_blocked", cpu_ready, 0);
    tick();
    chk("ldr_b2_addr", wr_addr, 32'h2000_0004);
    ldr_valid = 1'b0;
    #1;
    chk("ldr_gap_cpu_blocked", cpu_ready, 0);
    chk("ldr_gap_ldr_ready", ldr_ready, 0);
    tick();
    chk("ldr_gap_store", wr_store, 0);
    ldr_valid = 1'b1; ldr_addr = 32'h2000_0008; ldr_data = 32'h3333_3333; ldr_last = 1'b1;
    #1;
    chk("ldr_b3_ready", ldr_ready, 1);
    chk("ldr_b3_cpu_blocked", cpu_ready, 0);
    tick();
    chk("ldr_b3_addr", wr_addr, 32'h2000_0008);
    chk("ldr_b3_src", wr_src, 1);
    ldr_valid = 1'b0;
    #1;
    chk("post_burst_cpu_ready", cpu_ready, 1);
    tick();
    chk("post_burst_addr", wr_addr, 32'h3000_0000);
    chk("post_burst_src", wr_src, 0);

    // Stall with both valid: readys low, outputs frozen
    cpu_data = 32'hBBBB_BBBB; ldr_valid = 1'b1; ldr_last = 1'b1; wr_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_cpu_ready", cpu_ready, 0);
      chk("stall_ldr_ready", ldr_ready, 0);
      tick();
      chk("stall_store_held", wr_store, 1);
      chk("stall_data_held", wr_data, 32'hA5A5_A5A5);
    end
    wr_stall = 1'b0;
    #1;
    chk("unstall_cpu_ready", cpu_ready, 1);
    chk("unstall_ldr_ready", ldr_ready, 0);
    tick();
    chk("unstall_data", wr_data, 32'hBBBB_BBBB);

    // Illegal size
    ldr_valid = 1'b0; cpu_size = 3'b011; cpu_data = 32'hCCCC_CCCC;
    #1;
    chk("bad_size_ready", cpu_ready, 1);
    tick();
    chk("bad_size_err", err_size, 1);
    chk("bad_size_store", wr_store, 0);
    cpu_valid = 1'b0; cpu_size = 3'b010;
    tick();
    chk("bad_size_err_clear", err_size, 0);

    // Single-beat loader burst stays in IDLE
    ldr_valid = 1'b1; ldr_addr = 32'h4000_0000; ldr_last = 1'b1;
    #1;
    chk("single_ldr_ready", ldr_ready, 1);
    tick();
    chk("single_ldr_src", wr_src, 1);

    // Contention: fairness pattern C,C,L repeating, else CPU always
    cpu_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
`ifdef STORE_ARB_FAIRNESS_EN
      exp_cpu = (i % 3) != 2;
`else
      exp_cpu = 1'b1;
`endif
      #1;
      chk("contend_cpu_ready", cpu_ready, exp_cpu);
      chk("contend_ldr_ready", ldr_ready, !exp_cpu);
      tick();
      chk("contend_src", wr_src, !exp_cpu);
    end

    // Reset mid-burst
    cpu_valid = 1'b0; ldr_last = 1'b0;
    #1;
    chk("mid_b1_ldr_ready", ldr_ready, 1);
    tick();
    ldr_addr = 32'h4000_0004;
    tick();
    chk("mid_b2_src", wr_src, 1);
    cpu_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_store", wr_store, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_data", wr_data, 0);
    chk("mid_rst_src", wr_src, 0);
    chk("mid_rst_cpu_ready", cpu_ready, 0);
    chk("mid_rst_ldr_ready", ldr_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_cpu_ready", cpu_ready, 1);
    chk("post_rst_ldr_ready", ldr_ready, 0);
    tick();
    chk("post_rst_src", wr_src, 0);
    chk("post_rst_store", wr_store, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
